// File: rtl/mlp_wmem_arbiter_if.sv
// Bus bundle for the weight-memory arbiter: compute read port, loader write
// port, SRAM-side port and the conflict statistic.
interface mlp_wmem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic          rd_valid_i;
  logic          rd_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_data_valid_o;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic [15:0]   conflict_cnt_o;

  // Arbiter side
  modport slave (
    input  rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
    output rd_ready_o, rd_data_o, rd_data_valid_o, wr_ready_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, conflict_cnt_o
  );

  // Requester / SRAM side
  modport master (
    output rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
    input  rd_ready_o, rd_data_o, rd_data_valid_o, wr_ready_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, conflict_cnt_o
  );
endinterface

// File: rtl/mlp_wmem_arbiter.sv
// Single-port weight SRAM arbiter: compute reads have priority, an aging
// counter lets a starved loader write through after MAX_WAIT blocked cycles.
// SRAM-side signals are registered, so read data returns two cycles after
// the read handshake.
module mlp_wmem_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  mlp_wmem_arbiter_if.slave bus
);
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic          rd_ready;
  logic          wr_ready;
  logic          rd_hs;
  logic          wr_hs;
  logic [7:0]    wait_cnt;
  logic          rd_pend;
  logic          rd_data_valid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [15:0]   conflict_cnt;

  // Grant: write wins if it is alone or has aged out; otherwise a read wins.
  always_comb begin
    wr_ready = bus.wr_valid_i & (~bus.rd_valid_i | (wait_cnt == MAX_WAIT_C));
    rd_ready = bus.rd_valid_i & ~wr_ready;
    rd_hs    = rd_ready;
    wr_hs    = wr_ready;
  end

  // Registered SRAM command; address/data hold when idle, wdata holds on reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= rd_hs | wr_hs;
      mem_we <= wr_hs;
      if (wr_hs) begin
        mem_addr  <= bus.wr_addr_i;
        mem_wdata <= bus.wr_data_i;
      end else if (rd_hs) begin
        mem_addr <= bus.rd_addr_i;
      end
    end
  end

  // Read return pipeline: accepted read -> SRAM access -> data valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_pend       <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_pend       <= rd_hs;
      rd_data_valid <= rd_pend;
    end
  end

  // Aging counter: counts blocked write cycles, cleared when a write lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (wr_hs) begin
      wait_cnt <= '0;
    end else if (bus.wr_valid_i && (wait_cnt != MAX_WAIT_C)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Saturating count of cycles where both requesters contend.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt <= '0;
    end else if (bus.rd_valid_i && bus.wr_valid_i && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign bus.rd_ready_o      = rd_ready;
  assign bus.wr_ready_o      = wr_ready;
  assign bus.rd_data_o       = bus.mem_rdata_i;
  assign bus.rd_data_valid_o = rd_data_valid;
  assign bus.mem_en_o        = mem_en;
  assign bus.mem_we_o        = mem_we;
  assign bus.mem_addr_o      = mem_addr;
  assign bus.mem_wdata_o     = mem_wdata;
  assign bus.conflict_cnt_o  = conflict_cnt;
endmodule

// File: tb/tb_mlp_wmem_arbiter.sv
// Self-checking bench for mlp_wmem_arbiter: directed table, hand-written
// corner sequences, and randomized traffic against a reference model.
module tb_mlp_wmem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MAX_WAIT = 8;

  logic clk;
  logic rst;

  mlp_wmem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mlp_wmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) sram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i <= sram[bus.mem_addr_o];
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  typedef struct { int due; logic [DW-1:0] data; } rexp_t;
  rexp_t         rq[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            cyc = 0;
  int            m_wait = 0;
  int            m_conf = 0;
  logic          e_en = 0, e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive, check grants before the edge, check registered
  // outputs after the edge.
  task automatic step(input logic rv, input logic [AW-1:0] ra, input logic wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      output logic o_rr, output logic o_wr,
                      output logic o_dv, output logic [DW-1:0] o_data);
    logic e_rr, e_wr, e_dv;
    bus.rd_valid_i = rv;
    bus.rd_addr_i  = ra;
    bus.wr_valid_i = wv;
    bus.wr_addr_i  = wa;
    bus.wr_data_i  = wd;
    #3;
    e_wr = wv && (!rv || m_wait >= MAX_WAIT);
    e_rr = rv && !e_wr;
    chk("rd_ready", bus.rd_ready_o, e_rr);
    chk("wr_ready", bus.wr_ready_o, e_wr);
    o_rr = bus.rd_ready_o;
    o_wr = bus.wr_ready_o;
    if (e_wr) begin
      e_en = 1; e_we = 1; e_addr = wa; e_wdata = wd;
      shadow[wa] = wd;
      m_wait = 0;
    end else if (e_rr) begin
      e_en = 1; e_we = 0; e_addr = ra;
      rq.push_back('{due: cyc + 2, data: shadow[ra]});
    end else begin
      e_en = 0; e_we = 0;
    end
    if (!e_wr && wv && m_wait < MAX_WAIT) m_wait++;
    if (rv && wv && m_conf < 16'hFFFF) m_conf++;
    @(posedge clk);
    #1;
    cyc++;
    chk("mem_en", bus.mem_en_o, e_en);
    chk("mem_we", bus.mem_we_o, e_we);
    chk("mem_addr", bus.mem_addr_o, e_addr);
    chk("mem_wdata", bus.mem_wdata_o, e_wdata);
    chk("conflict_cnt", bus.conflict_cnt_o, m_conf);
    e_dv = (rq.size() > 0) && (rq[0].due == cyc);
    chk("rd_data_valid", bus.rd_data_valid_o, e_dv);
    if (e_dv) begin
      chk("rd_data", bus.rd_data_o, rq[0].data);
      void'(rq.pop_front());
    end
    o_dv   = bus.rd_data_valid_o;
    o_data = bus.rd_data_o;
  endtask

  // Assert reset asynchronously mid-cycle, check outputs drop at once,
  // release away from the clock edge.
  task automatic do_reset();
    bus.rd_valid_i = 0;
    bus.wr_valid_i = 0;
    rst = 1;
    #1;
    chk("rst_mem_en", bus.mem_en_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_rd_data_valid", bus.rd_data_valid_o, 0);
    chk("rst_conflict_cnt", bus.conflict_cnt_o, 0);
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    m_wait = 0; m_conf = 0;
    rq.delete();
    @(posedge clk);
    #2;
    rst = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rr;
    logic          wr;
    logic          dv;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vt[$];

  initial begin
    logic rr, wr, dv;
    logic [DW-1:0] d;
    logic r_pend, w_pend;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] w_data;

    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = '0;
      shadow[i] = '0;
    end
    bus.rd_valid_i = 0; bus.rd_addr_i = '0;
    bus.wr_valid_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.mem_rdata_i = '0;
    rst = 1;
    #2;
    chk("init_mem_en", bus.mem_en_o, 0);
    chk("init_rd_data_valid", bus.rd_data_valid_o, 0);
    chk("init_conflict_cnt", bus.conflict_cnt_o, 0);
    @(posedge clk);
    #2;
    rst = 0;
    @(posedge clk);
    #1;

    // Loader fills 0x000..0x00F; then a lone read; then write/read same address.
    for (int i = 0; i < 16; i++)
      vt.push_back('{0, '0, 1, AW'(i), DW'(32'hA0 + i), 0, 1, 0, '0});
    vt.push_back('{1, 11'h005, 0, '0, '0, 1, 0, 0, '0});
    vt.push_back('{0, '0, 0, '0, '0, 0, 0, 1, 32'hA5});
    vt.push_back('{0, '0, 0, '0, '0, 0, 0, 0, '0});
    vt.push_back('{0, '0, 1, 11'h7FF, 32'h1234, 0, 1, 0, '0});
    vt.push_back('{1, 11'h7FF, 0, '0, '0, 1, 0, 0, '0});
    vt.push_back('{0, '0, 0, '0, '0, 0, 0, 1, 32'h1234});
    vt.push_back('{0, '0, 0, '0, '0, 0, 0, 0, '0});
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rv, vt[i].ra, vt[i].wv, vt[i].wa, vt[i].wd, rr, wr, dv, d);
      chk($sformatf("vec%0d_rd_ready", i), rr, vt[i].rr);
      chk($sformatf("vec%0d_wr_ready", i), wr, vt[i].wr);
      chk($sformatf("vec%0d_dv", i), dv, vt[i].dv);
      if (vt[i].dv) chk($sformatf("vec%0d_data", i), d, vt[i].data);
    end
    chk("t1_conflict_zero", bus.conflict_cnt_o, 0);

    // Continuous reads against a waiting write: aging grants at 8 and 17.
    w_addr = 11'h100; w_data = 32'hBEEF_0000;
    for (int i = 0; i < 20; i++) begin
      step(1, AW'($urandom_range(0, 15)), 1, w_addr, w_data, rr, wr, dv, d);
      chk($sformatf("t3_c%0d_rd_ready", i), rr, (i != 8 && i != 17));
      chk($sformatf("t3_c%0d_wr_ready", i), wr, (i == 8 || i == 17));
      if (wr) begin w_addr++; w_data++; end
    end
    chk("t3_conflict_20", bus.conflict_cnt_o, 20);
    step(0, '0, 0, '0, '0, rr, wr, dv, d);
    step(0, '0, 0, '0, '0, rr, wr, dv, d);

    // Reset one cycle after a read handshake: read is dropped.
    step(1, 11'h00A, 0, '0, '0, rr, wr, dv, d);
    chk("t5_read_accepted", rr, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, '0, '0, rr, wr, dv, d);
      chk("t5_no_stale_dv", dv, 0);
    end
    step(1, 11'h00A, 0, '0, '0, rr, wr, dv, d);
    step(0, '0, 0, '0, '0, rr, wr, dv, d);
    chk("t5_dv_after_reset", dv, 1);
    chk("t5_data_after_reset", d, 32'hAA);
    step(0, '0, 0, '0, '0, rr, wr, dv, d);

    // Randomized traffic with requester holding valid/addr/data until accepted.
    r_pend = 0; w_pend = 0; r_addr = '0; w_addr = '0; w_data = '0;
    for (int i = 0; i < 400; i++) begin
      if (!r_pend && ($urandom_range(0, 2) != 0)) begin
        r_pend = 1; r_addr = AW'($urandom_range(0, 31));
      end
      if (!w_pend && ($urandom_range(0, 2) == 0)) begin
        w_pend = 1; w_addr = AW'($urandom_range(0, 31)); w_data = $urandom;
      end else if (w_pend && ($urandom_range(0, 15) == 0)) begin
        w_pend = 0;
      end
      step(r_pend, r_addr, w_pend, w_addr, w_data, rr, wr, dv, d);
      if (rr) r_pend = 0;
      if (wr) w_pend = 0;
    end
    step(0, '0, 0, '0, '0, rr, wr, dv, d);
    step(0, '0, 0, '0, '0, rr, wr, dv, d);

    // Saturation of the conflict counter.
    do_reset();
    w_addr = 11'h200; w_data = 32'h5000_0000;
    for (int i = 0; i < 65540; i++) begin
      step(1, AW'(i[4:0]), 1, w_addr, w_data, rr, wr, dv, d);
      if (wr) begin w_addr = AW'(11'h200 + w_data[3:0]); w_data++; end
    end
    chk("t6_conflict_sat", bus.conflict_cnt_o, 16'hFFFF);
    for (int i = 0; i < 3; i++) step(1, '0, 1, w_addr, w_data, rr, wr, dv, d);
    chk("t6_conflict_hold", bus.conflict_cnt_o, 16'hFFFF);
    step(0, '0, 0, '0, '0, rr, wr, dv, d);
    step(0, '0, 0, '0, '0, rr, wr, dv, d);
    chk("final_queue_empty", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
